// File: rtl/matmul_pkg.sv
// Shared state type and arithmetic helpers for the sequential N x N matrix multiplier.
package matmul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    function automatic int acc_width(input int n, input int w);
        return 2 * w + $clog2(n);
    endfunction

    // Full-precision sums arrive sign- or zero-extended to 64 bits, so one compare pair covers both modes
    function automatic longint clamp(input longint value, input int w, input bit isSigned);
        longint hi;
        longint lo;
        if (isSigned) begin
            hi = (longint'(1) << (w - 1)) - longint'(1);
            lo = -(longint'(1) << (w - 1));
        end else begin
            hi = (longint'(1) << w) - longint'(1);
            lo = longint'(0);
        end
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/matmul_seq_if.sv
// Operand/result handshake bundle between the operand source, matmul_seq and the result consumer.
interface matmul_seq_if #(
    parameter int N = 3,
    parameter int W = 4
) ();

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A [N*N];
    logic [W-1:0] B [N*N];
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] C [N*N];

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  out_ready,
        output in_ready,
        output out_valid,
        output C
    );

    modport master (
        output in_valid,
        output A,
        output B,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  C
    );

endinterface

// File: rtl/matmul_mac.sv
// Time-shared multiply-accumulate unit: full-precision accumulator with a wrap or saturate output stage.
module matmul_mac
    import matmul_pkg::*;
#(
    parameter int N        = 3,
    parameter int W        = 4,
    parameter bit SIGNED   = 1'b1,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         en_i,
    input  logic         last_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] result_o
);

    localparam int AW = acc_width(N, W);

    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [AW-1:0] aExt;
    logic [AW-1:0] bExt;
    logic [AW-1:0] product;
    logic [AW-1:0] accSum;

    // Low AW bits of an unsigned multiply of extended operands equal the exact signed product
    generate
        if (SIGNED) begin : g_signed
            assign aExt = {{(AW - W){a_i[W-1]}}, a_i};
            assign bExt = {{(AW - W){b_i[W-1]}}, b_i};
        end else begin : g_unsigned
            assign aExt = {{(AW - W){1'b0}}, a_i};
            assign bExt = {{(AW - W){1'b0}}, b_i};
        end
    endgenerate

    assign product = aExt * bExt;
    assign accSum  = acc_q + product;

    generate
        if (SATURATE) begin : g_sat
            logic [63:0] sumWide;
            assign sumWide  = SIGNED ? {{(64 - AW){accSum[AW-1]}}, accSum}
                                     : {{(64 - AW){1'b0}}, accSum};
            assign result_o = W'(clamp($signed(sumWide), W, SIGNED));
        end else begin : g_wrap
            assign result_o = accSum[W-1:0];
        end
    endgenerate

    // The final term of each dot product is emitted through result_o and the accumulator restarts at zero
    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = last_i ? '0 : accSum;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matmul_seq.sv
// Sequential C = A x B over N x N row-major matrices, one MAC per cycle, valid/ready on both sides.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int N        = 3,
    parameter int W        = 4,
    parameter bit SIGNED   = 1'b1,
    parameter bit SATURATE = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    matmul_seq_if.slave   bus
);

    localparam int            NN   = N * N;
    localparam int            IW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_e        state_q;
    state_e        state_d;
    logic [IW-1:0] i_q;
    logic [IW-1:0] i_d;
    logic [IW-1:0] j_q;
    logic [IW-1:0] j_d;
    logic [IW-1:0] k_q;
    logic [IW-1:0] k_d;
    logic [W-1:0]  aReg_q [NN];
    logic [W-1:0]  bReg_q [NN];
    logic [W-1:0]  c_q    [NN];

    logic          load;
    logic          macClear;
    logic          macEn;
    logic          macLast;
    logic [W-1:0]  aSel;
    logic [W-1:0]  bSel;
    logic [W-1:0]  macResult;
    int            aIdx;
    int            bIdx;
    int            cIdx;

    // Operand selection: a[i][k] and b[k][j] out of the latched row-major copies
    always_comb begin
        aIdx = int'(i_q) * N + int'(k_q);
        bIdx = int'(k_q) * N + int'(j_q);
        cIdx = int'(i_q) * N + int'(j_q);
        aSel = '0;
        bSel = '0;
        for (int e = 0; e < NN; e++) begin
            if (e == aIdx) begin
                aSel = aReg_q[e];
            end
            if (e == bIdx) begin
                bSel = bReg_q[e];
            end
        end
    end

    matmul_mac #(
        .N        (N),
        .W        (W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (macClear),
        .en_i     (macEn),
        .last_i   (macLast),
        .a_i      (aSel),
        .b_i      (bSel),
        .result_o (macResult)
    );

    // Loop order is k innermost, then j, then i, so C fills in row-major order
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        load     = 1'b0;
        macClear = 1'b0;
        macEn    = 1'b0;
        macLast  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    load     = 1'b1;
                    macClear = 1'b1;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                macEn = 1'b1;
                if (k_q == LAST) begin
                    macLast = 1'b1;
                    k_d     = '0;
                    if (j_q == LAST) begin
                        j_d = '0;
                        if (i_q == LAST) begin
                            i_d     = '0;
                            state_d = DONE;
                        end else begin
                            i_d = i_q + IW'(1);
                        end
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            for (int e = 0; e < NN; e++) begin
                aReg_q[e] <= '0;
                bReg_q[e] <= '0;
                c_q[e]    <= '0;
            end
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            for (int e = 0; e < NN; e++) begin
                if (load) begin
                    aReg_q[e] <= bus.A[e];
                    bReg_q[e] <= bus.B[e];
                end
                if (macLast && (e == cIdx)) begin
                    c_q[e] <= macResult;
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);

    always_comb begin
        for (int e = 0; e < NN; e++) begin
            bus.C[e] = c_q[e];
        end
    end

endmodule
